// File: rtl/int_to_float_pkg.sv
// Shared definitions for the integer-to-float converter and the float datapath
// it feeds: state encoding, exponent constants and IEEE754 field widths.
package int_to_float_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_NORM  = 2'b01,
    ST_ROUND = 2'b10
  } state_t;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

  localparam logic [EXP_W-1:0] EXP_BIAS      = 8'd127;
  // Exponent of a 32-bit magnitude whose MSB sits at bit 31.
  localparam logic [EXP_W-1:0] EXP_INT32_TOP = EXP_BIAS + 8'd31;

endpackage

// File: rtl/int_to_float_rne_round.sv
// Round-to-nearest-even of a normalized 32-bit magnitude (MSB at bit 31)
// down to a 23-bit fraction, bumping the exponent on mantissa carry-out.
module rne_round
  import int_to_float_pkg::*;
(
  input  logic [31:0]       mag,
  input  logic [EXP_W-1:0]  biased_exp,
  output logic [MANT_W-1:0] mant,
  output logic [EXP_W-1:0]  round_exp
);

  logic        lsb;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] m24;

  assign lsb      = mag[8];
  assign guard    = mag[7];
  assign sticky   = |mag[6:0];
  assign round_up = guard & (sticky | lsb);

  // Sum includes the hidden bit; with a normalized input a carry-out of the
  // fraction wraps the hidden bit to 0, which is the exponent-bump condition.
  assign m24       = mag[31:8] + {23'd0, round_up};
  assign mant      = m24[MANT_W-1:0];
  assign round_exp = biased_exp + {{(EXP_W-1){1'b0}}, ~m24[23]};

endmodule

// File: rtl/int_to_float.sv
// Multi-cycle 32-bit integer to IEEE754 single converter: one-bit-per-cycle
// normalization followed by a single round-to-nearest-even step.
module int_to_float
  import int_to_float_pkg::*;
#(
  parameter logic SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  output logic        busy,
  output logic        valid,
  output logic [31:0] result
);

  state_t            state_reg, state_next;
  logic [31:0]       mag_reg, mag_next;
  logic [EXP_W-1:0]  exp_reg, exp_next;
  logic              sign_reg, sign_next;
  logic              valid_reg, valid_next;
  logic [31:0]       result_reg, result_next;

  logic              in_sign;
  logic [31:0]       in_mag;
  logic [MANT_W-1:0] rnd_mant;
  logic [EXP_W-1:0]  rnd_exp;

  // Two's-complement negation in 32 bits: -2^31 maps onto 0x80000000.
  assign in_sign = SIGNED & A[31];
  assign in_mag  = in_sign ? (~A + 32'd1) : A;

  rne_round u_rne_round (
    .mag        (mag_reg),
    .biased_exp (exp_reg),
    .mant       (rnd_mant),
    .round_exp  (rnd_exp)
  );

  always_comb begin
    state_next  = state_reg;
    mag_next    = mag_reg;
    exp_next    = exp_reg;
    sign_next   = sign_reg;
    valid_next  = 1'b0;
    result_next = result_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (A == 32'd0) begin
            result_next = 32'd0;
            valid_next  = 1'b1;
          end else begin
            sign_next  = in_sign;
            mag_next   = in_mag;
            exp_next   = EXP_INT32_TOP;
            // The MSB test looks at the value being loaded, so an already
            // normalized magnitude spends no cycle in NORM.
            state_next = in_mag[31] ? ST_ROUND : ST_NORM;
          end
        end
      end
      ST_NORM: begin
        mag_next = mag_reg << 1;
        exp_next = exp_reg - 8'd1;
        if (mag_reg[30]) begin
          state_next = ST_ROUND;
        end
      end
      ST_ROUND: begin
        result_next = {sign_reg, rnd_exp, rnd_mant};
        valid_next  = 1'b1;
        state_next  = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      mag_reg    <= 32'd0;
      exp_reg    <= '0;
      sign_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      result_reg <= 32'd0;
    end else begin
      state_reg  <= state_next;
      mag_reg    <= mag_next;
      exp_reg    <= exp_next;
      sign_reg   <= sign_next;
      valid_reg  <= valid_next;
      result_reg <= result_next;
    end
  end

  assign busy   = (state_reg != ST_IDLE);
  assign valid  = valid_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_int_to_float.sv
// Directed-vector bench for int_to_float: signed and unsigned instances,
// conversion table plus handshake and reset sequences.
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s;
  logic        start_u;
  logic [31:0] A;
  logic        busy_s, valid_s, busy_u, valid_u;
  logic [31:0] result_s, result_u;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  int_to_float #(.SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .A(A),
    .busy(busy_s), .valid(valid_s), .result(result_s)
  );

  int_to_float #(.SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .start(start_u), .A(A),
    .busy(busy_u), .valid(valid_u), .result(result_u)
  );

  typedef struct {
    bit          uns;
    logic [31:0] a;
    logic [31:0] res;
    int          vcyc;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Called just after a rising edge; that cycle is cycle 0 of the request.
  task automatic conv(input bit uns, input logic [31:0] a,
                      output logic [31:0] res, output int vcyc, output int bcnt);
    A = a;
    if (uns) start_u = 1'b1; else start_s = 1'b1;
    res  = 32'hxxxxxxxx;
    vcyc = -1;
    bcnt = 0;
    for (int c = 1; c <= 40 && vcyc < 0; c++) begin
      @(posedge clk); #1;
      start_s = 1'b0;
      start_u = 1'b0;
      if (uns ? busy_u : busy_s) bcnt++;
      if (uns ? valid_u : valid_s) begin
        vcyc = c;
        res  = uns ? result_u : result_s;
      end
    end
  endtask

  initial begin
    logic [31:0] res;
    int vcyc, bcnt, nvalid, first_v;
    logic [31:0] first_res;

    vecs[0]  = '{1'b0, 32'h00000001, 32'h3F800000, 33};
    vecs[1]  = '{1'b0, 32'hFFFFFFFF, 32'hBF800000, 33};
    vecs[2]  = '{1'b0, 32'h80000000, 32'hCF000000, 2};
    vecs[3]  = '{1'b0, 32'h00000000, 32'h00000000, 1};
    vecs[4]  = '{1'b0, 32'd16777217, 32'h4B800000, 9};
    vecs[5]  = '{1'b0, 32'd16777219, 32'h4B800002, 9};
    vecs[6]  = '{1'b0, 32'd16777221, 32'h4B800002, 9};
    vecs[7]  = '{1'b1, 32'hFFFFFFFF, 32'h4F800000, 2};
    vecs[8]  = '{1'b0, 32'h00000003, 32'h40400000, 32};
    vecs[9]  = '{1'b0, 32'h00000002, 32'h40000000, 32};
    vecs[10] = '{1'b0, 32'h00000007, 32'h40E00000, 31};
    vecs[11] = '{1'b0, 32'hFFFFFF9C, 32'hC2C80000, 27};
    vecs[12] = '{1'b1, 32'h80000000, 32'h4F000000, 2};

    rst = 1'b1; start_s = 1'b0; start_u = 1'b0; A = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy_s", {31'd0, busy_s}, 32'd0);
    check("reset valid_s", {31'd0, valid_s}, 32'd0);
    check("reset result_s", result_s, 32'd0);
    check("reset busy_u", {31'd0, busy_u}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      conv(vecs[i].uns, vecs[i].a, res, vcyc, bcnt);
      $display("[TB] vec %0d uns=%0d A=0x%08h -> 0x%08h valid@%0d busy=%0d",
               i, vecs[i].uns, vecs[i].a, res, vcyc, bcnt);
      check($sformatf("vec%0d result", i), res, vecs[i].res);
      check($sformatf("vec%0d valid cycle", i), vcyc, vecs[i].vcyc);
      check($sformatf("vec%0d busy cycles", i), bcnt, vecs[i].vcyc - 1);
      @(posedge clk); #1;
    end

    // Second start while busy on A=3 must be dropped.
    A = 32'd3; start_s = 1'b1;
    nvalid = 0; first_v = -1; first_res = 32'd0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      start_s = (c == 5);
      if (c == 5) A = 32'd5;
      if (valid_s) begin
        nvalid++;
        if (first_v < 0) begin first_v = c; first_res = result_s; end
      end
    end
    $display("[TB] drop: valids=%0d first@%0d result=0x%08h", nvalid, first_v, first_res);
    check("drop valid count", nvalid, 32'd1);
    check("drop valid cycle", first_v, 32'd32);
    check("drop result", first_res, 32'h40400000);

    // Back-to-back: start issued in the valid cycle of the previous request.
    conv(1'b0, 32'd2, res, vcyc, bcnt);
    check("b2b first result", res, 32'h40000000);
    conv(1'b0, 32'd7, res, vcyc, bcnt);
    $display("[TB] b2b: A=7 -> 0x%08h valid@%0d", res, vcyc);
    check("b2b result", res, 32'h40E00000);
    check("b2b valid cycle", vcyc, 32'd31);

    // Reset in cycle 10 of A=1.
    A = 32'd1; start_s = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start_s = 1'b0;
    end
    check("pre-reset busy", {31'd0, busy_s}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("[TB] reset abort: busy=%0d valid=%0d result=0x%08h", busy_s, valid_s, result_s);
    check("abort busy", {31'd0, busy_s}, 32'd0);
    check("abort valid", {31'd0, valid_s}, 32'd0);
    check("abort result", result_s, 32'd0);
    nvalid = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (valid_s) nvalid++;
    end
    check("abort no valid", nvalid, 32'd0);
    conv(1'b0, 32'd2, res, vcyc, bcnt);
    $display("[TB] after reset: A=2 -> 0x%08h valid@%0d", res, vcyc);
    check("after reset result", res, 32'h40000000);
    check("after reset valid cycle", vcyc, 32'd32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
